cache_controller: RTL and testbench

// - Direct-mapped, write-back, write-allocate cache controller between a CPU request port and a block-wide memory port.
// - Holds tag, valid, dirty and 128-bit data arrays internally.
// - CPU reads return one 32-bit word. CPU writes supply a full 128-bit line.
// - Misses are served by a 4-state FSM that does at most one write-back and one line fill per request.

---
 rtl/cache_controller.sv | 172 +++++++++++++++++
 tb/tb_cache_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// cache_controller
//   Direct-mapped, write-back, write-allocate cache between a CPU request
//   port and a line-wide memory port. Tag, valid, dirty and line data
//   arrays are held internally. Reads return one 32-bit word. Writes
//   supply a whole line. Misses are served by a four-state FSM that does
//   at most one write-back and one line fill per request.
//
// Ports
//   clk              clock, all logic on the rising edge
//   rst_n            synchronous reset, ACTIVE-HIGH despite the legacy name
//   cpu_req_addr     CPU byte address
//   cpu_req_datain   CPU write line
//   cpu_req_dataout  read word, line word selected by addr[3:2]
//   cpu_req_rw       1 = write, 0 = read
//   cpu_req_valid    CPU request valid (sampled only while cache_ready)
//   cache_ready      1 while idle
//   mem_req_addr     memory block address {tag, index, 0}
//   mem_req_datain   fill data from memory
//   mem_req_dataout  write-back data to memory
//   mem_req_rw       1 = write-back, 0 = fill
//   mem_req_valid    memory request outstanding
//   mem_req_ready    memory completes the request in the cycle it is high
module cache_controller #(
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 128,
    parameter int INDEX_W  = 10,
    parameter int OFFSET_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [LINE_W-1:0] cpu_req_datain,
    output logic [31:0]       cpu_req_dataout,
    input  logic              cpu_req_rw,
    input  logic              cpu_req_valid,
    output logic              cache_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic [LINE_W-1:0] mem_req_datain,
    output logic [LINE_W-1:0] mem_req_dataout,
    output logic              mem_req_rw,
    output logic              mem_req_valid,
    input  logic              mem_req_ready
);

    localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
    localparam int NUM_LINES = 1 << INDEX_W;
    localparam int WSEL_W    = OFFSET_W - 2;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] COMPARE    = 2'd1;
    localparam logic [1:0] WRITE_BACK = 2'd2;
    localparam logic [1:0] ALLOCATE   = 2'd3;

    logic [1:0]          state;

    logic [ADDR_W-1:0]   req_addr;
    logic [LINE_W-1:0]   req_data;
    logic                req_rw;

    logic [TAG_W-1:0]    tag_mem  [NUM_LINES];
    logic [LINE_W-1:0]   data_mem [NUM_LINES];
    logic [NUM_LINES-1:0] valid_bits;
    logic [NUM_LINES-1:0] dirty_bits;

    logic [INDEX_W-1:0]  req_index;
    logic [TAG_W-1:0]    req_tag;
    logic [WSEL_W-1:0]   word_sel;
    logic [TAG_W-1:0]    cur_tag;
    logic [LINE_W-1:0]   cur_line;
    logic                hit;
    logic                victim_dirty;
    logic [31:0]         sel_word;

    // Byte-within-word address bits have no meaning for a word/line cache.
    logic unused_byte_bits;
    assign unused_byte_bits = &{1'b0, req_addr[1:0]};

    assign cache_ready = (state == IDLE);

    always_comb begin
        req_index    = req_addr[OFFSET_W +: INDEX_W];
        req_tag      = req_addr[ADDR_W-1 -: TAG_W];
        word_sel     = req_addr[OFFSET_W-1:2];
        cur_tag      = tag_mem[req_index];
        cur_line     = data_mem[req_index];
        hit          = valid_bits[req_index] && (cur_tag == req_tag);
        victim_dirty = valid_bits[req_index] && dirty_bits[req_index];
        sel_word     = cur_line[{word_sel, 5'b00000} +: 32];
    end

    // Control state, valid/dirty bits and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state           <= IDLE;
            valid_bits      <= '0;
            dirty_bits      <= '0;
            req_addr        <= '0;
            req_data        <= '0;
            req_rw          <= 1'b0;
            mem_req_valid   <= 1'b0;
            mem_req_rw      <= 1'b0;
            mem_req_addr    <= '0;
            mem_req_dataout <= '0;
            cpu_req_dataout <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req_valid) begin
                        req_addr <= cpu_req_addr;
                        req_data <= cpu_req_datain;
                        req_rw   <= cpu_req_rw;
                        state    <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        if (req_rw) begin
                            dirty_bits[req_index] <= 1'b1;
                        end else begin
                            cpu_req_dataout <= sel_word;
                        end
                        state <= IDLE;
                    end else if (victim_dirty) begin
                        mem_req_valid   <= 1'b1;
                        mem_req_rw      <= 1'b1;
                        mem_req_addr    <= {cur_tag, req_index, {OFFSET_W{1'b0}}};
                        mem_req_dataout <= cur_line;
                        state           <= WRITE_BACK;
                    end else begin
                        mem_req_valid <= 1'b1;
                        mem_req_rw    <= 1'b0;
                        mem_req_addr  <= {req_tag, req_index, {OFFSET_W{1'b0}}};
                        state         <= ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    // Write-back done: switch straight to the fill without
                    // dropping mem_req_valid.
                    if (mem_req_ready) begin
                        mem_req_rw   <= 1'b0;
                        mem_req_addr <= {req_tag, req_index, {OFFSET_W{1'b0}}};
                        state        <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    // Line installed; COMPARE re-runs and now hits.
                    if (mem_req_ready) begin
                        valid_bits[req_index] <= 1'b1;
                        dirty_bits[req_index] <= 1'b0;
                        mem_req_valid         <= 1'b0;
                        state                 <= COMPARE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays are never cleared; writes are suppressed in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if (state == COMPARE && hit && req_rw) begin
                data_mem[req_index] <= req_data;
            end
            if (state == ALLOCATE && mem_req_ready) begin
                data_mem[req_index] <= mem_req_datain;
                tag_mem[req_index]  <= req_tag;
            end
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller
//   Directed, table-driven bench for cache_controller. A small memory
//   responder answers write-back and fill requests with per-vector fill data
//   and an optional number of stall cycles per memory phase. Expected
//   traffic and read data are hand-computed in the vector table.
module tb_cache_controller;

    logic         clk;
    logic         rst_n;
    logic [31:0]  cpu_req_addr;
    logic [127:0] cpu_req_datain;
    logic [31:0]  cpu_req_dataout;
    logic         cpu_req_rw;
    logic         cpu_req_valid;
    logic         cache_ready;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_datain;
    logic [127:0] mem_req_dataout;
    logic         mem_req_rw;
    logic         mem_req_valid;
    logic         mem_req_ready;

    cache_controller #(
        .ADDR_W   (32),
        .LINE_W   (128),
        .INDEX_W  (10),
        .OFFSET_W (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cpu_req_addr    (cpu_req_addr),
        .cpu_req_datain  (cpu_req_datain),
        .cpu_req_dataout (cpu_req_dataout),
        .cpu_req_rw      (cpu_req_rw),
        .cpu_req_valid   (cpu_req_valid),
        .cache_ready     (cache_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_req_datain  (mem_req_datain),
        .mem_req_dataout (mem_req_dataout),
        .mem_req_rw      (mem_req_rw),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [127:0] fill;
        int unsigned  delay;      // stall cycles per memory phase
        int unsigned  exp_wb;     // expected write-back count
        logic [31:0]  wb_addr;
        logic [127:0] wb_data;
        int unsigned  exp_fill;   // expected fill count
        logic [31:0]  fill_addr;
        logic [31:0]  exp_rdata;  // dataout after completion
        int unsigned  exp_lat;    // accept-to-ready edges, 0 = unchecked
    } vec_t;

    localparam int NVEC = 13;
    localparam logic [127:0] LINE_ABCD =
        {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};

    vec_t vecs [NVEC];
    int unsigned total;
    int unsigned bad;

    function automatic vec_t mk(input logic rw, input logic [31:0] addr,
                                input logic [127:0] wdata, input logic [127:0] fill,
                                input int unsigned delay,
                                input int unsigned exp_wb, input logic [31:0] wb_addr,
                                input logic [127:0] wb_data,
                                input int unsigned exp_fill, input logic [31:0] fill_addr,
                                input logic [31:0] exp_rdata, input int unsigned exp_lat);
        vec_t v;
        v.rw = rw; v.addr = addr; v.wdata = wdata; v.fill = fill; v.delay = delay;
        v.exp_wb = exp_wb; v.wb_addr = wb_addr; v.wb_data = wb_data;
        v.exp_fill = exp_fill; v.fill_addr = fill_addr;
        v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 50 && !cache_ready; i++) @(negedge clk);
        chk({name, " idle before request"}, 128'(cache_ready), 128'd1);
    endtask

    task automatic do_req(input string name, input vec_t v);
        int unsigned n_wb, n_fill, edges, phase_wait;
        logic [31:0]  wb_a, fill_a, s_addr;
        logic [127:0] wb_d, s_data;
        logic         s_rw;
        n_wb = 0; n_fill = 0; phase_wait = 0;
        wb_a = '0; fill_a = '0; wb_d = '0; s_addr = '0; s_data = '0; s_rw = 1'b0;
        wait_idle(name);
        cpu_req_valid  = 1'b1;
        cpu_req_rw     = v.rw;
        cpu_req_addr   = v.addr;
        cpu_req_datain = v.wdata;
        @(negedge clk);
        // CPU is free to drop its inputs after the accept edge
        cpu_req_valid  = 1'b0;
        cpu_req_rw     = ~v.rw;
        cpu_req_addr   = ~v.addr;
        cpu_req_datain = ~v.wdata;
        edges = 1;
        for (int c = 0; c < 60 && !cache_ready; c++) begin
            edges++;
            if (mem_req_valid) begin
                if (phase_wait == 0) begin
                    s_addr = mem_req_addr; s_rw = mem_req_rw; s_data = mem_req_dataout;
                end else begin
                    chk({name, " stall addr stable"}, 128'(mem_req_addr), 128'(s_addr));
                    chk({name, " stall rw stable"}, 128'(mem_req_rw), 128'(s_rw));
                    chk({name, " stall data stable"}, mem_req_dataout, s_data);
                end
                if (phase_wait < v.delay) begin
                    mem_req_ready = 1'b0;
                    phase_wait++;
                end else begin
                    if (mem_req_rw) begin
                        n_wb++; wb_a = mem_req_addr; wb_d = mem_req_dataout;
                    end else begin
                        n_fill++; fill_a = mem_req_addr;
                        mem_req_datain = v.fill;
                    end
                    mem_req_ready = 1'b1;
                    phase_wait = 0;
                end
            end else begin
                mem_req_ready = 1'b0;
            end
            @(negedge clk);
        end
        mem_req_ready  = 1'b0;
        mem_req_datain = '0;
        chk({name, " completes"}, 128'(cache_ready), 128'd1);
        chk({name, " no mem_req_valid at end"}, 128'(mem_req_valid), 128'd0);
        chk({name, " writeback count"}, 128'(n_wb), 128'(v.exp_wb));
        chk({name, " fill count"}, 128'(n_fill), 128'(v.exp_fill));
        if (v.exp_wb != 0) begin
            chk({name, " writeback addr"}, 128'(wb_a), 128'(v.wb_addr));
            chk({name, " writeback data"}, wb_d, v.wb_data);
        end
        if (v.exp_fill != 0)
            chk({name, " fill addr"}, 128'(fill_a), 128'(v.fill_addr));
        chk({name, " dataout"}, 128'(cpu_req_dataout), 128'(v.exp_rdata));
        if (v.exp_lat != 0)
            chk({name, " latency"}, 128'(edges), 128'(v.exp_lat));
    endtask

    initial begin
        vec_t post;
        total = 0;
        bad   = 0;
        //             rw    addr          wdata            fill          dly wb wb_addr     wb_data    fl fill_addr    rdata         lat
        vecs[0]  = mk(1'b1, 32'h0000_AB00, 128'h1122,       128'h0,       0, 0, 32'h0,       128'h0,    1, 32'h0000_AB00, 32'h0,        0);
        vecs[1]  = mk(1'b0, 32'h0000_AB00, 128'h0,          128'h0,       0, 0, 32'h0,       128'h0,    0, 32'h0,        32'h1122,     2);
        vecs[2]  = mk(1'b0, 32'h0000_BB00, 128'h0,          128'h3344,    0, 0, 32'h0,       128'h0,    1, 32'h0000_BB00, 32'h3344,     0);
        vecs[3]  = mk(1'b0, 32'h0000_EB00, 128'h0,          128'h5566,    0, 1, 32'h0000_AB00, 128'h1122, 1, 32'h0000_EB00, 32'h5566,   0);
        vecs[4]  = mk(1'b1, 32'h0000_BB08, LINE_ABCD,       128'h0,       0, 0, 32'h0,       128'h0,    0, 32'h0,        32'h5566,     2);
        vecs[5]  = mk(1'b0, 32'h0000_BB08, 128'h0,          128'h0,       0, 0, 32'h0,       128'h0,    0, 32'h0,        32'hCCCC_CCCC, 2);
        vecs[6]  = mk(1'b0, 32'h0000_BB0C, 128'h0,          128'h0,       0, 0, 32'h0,       128'h0,    0, 32'h0,        32'hDDDD_DDDD, 2);
        vecs[7]  = mk(1'b0, 32'h0000_BB04, 128'h0,          128'h0,       0, 0, 32'h0,       128'h0,    0, 32'h0,        32'hBBBB_BBBB, 2);
        vecs[8]  = mk(1'b0, 32'h0000_FB00, 128'h0,          128'h7788,    0, 1, 32'h0000_BB00, LINE_ABCD, 1, 32'h0000_FB00, 32'h7788,   0);
        vecs[9]  = mk(1'b1, 32'h0001_0000, 128'h4242,       128'h9999,    0, 0, 32'h0,       128'h0,    1, 32'h0001_0000, 32'h7788,     0);
        vecs[10] = mk(1'b0, 32'h0001_0000, 128'h0,          128'h0,       0, 0, 32'h0,       128'h0,    0, 32'h0,        32'h4242,     2);
        vecs[11] = mk(1'b0, 32'h0002_0010, 128'h0,          128'hBEEF,    3, 0, 32'h0,       128'h0,    1, 32'h0002_0010, 32'hBEEF,     0);
        vecs[12] = mk(1'b0, 32'h0003_0000, 128'h0,          128'h1357_2468, 2, 1, 32'h0001_0000, 128'h4242, 1, 32'h0003_0000, 32'h1357_2468, 0);

        cpu_req_addr   = '0;
        cpu_req_datain = '0;
        cpu_req_rw     = 1'b0;
        cpu_req_valid  = 1'b0;
        mem_req_datain = '0;
        mem_req_ready  = 1'b0;
        rst_n          = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset cache_ready", 128'(cache_ready), 128'd1);
        chk("reset mem_req_valid", 128'(mem_req_valid), 128'd0);
        chk("reset mem_req_rw", 128'(mem_req_rw), 128'd0);
        chk("reset mem_req_addr", 128'(mem_req_addr), 128'd0);
        chk("reset mem_req_dataout", mem_req_dataout, 128'd0);
        chk("reset cpu_req_dataout", 128'(cpu_req_dataout), 128'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle no traffic", 128'(mem_req_valid), 128'd0);
        end

        for (int i = 0; i < NVEC; i++)
            do_req($sformatf("vec%0d", i), vecs[i]);

        // Reset while a fill is outstanding (index 0x2B0 holds clean tag 3).
        wait_idle("rst_alloc");
        cpu_req_valid = 1'b1;
        cpu_req_rw    = 1'b0;
        cpu_req_addr  = 32'h0000_AB00;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        for (int i = 0; i < 10 && !mem_req_valid; i++) @(negedge clk);
        chk("rst_alloc fill issued", 128'(mem_req_valid), 128'd1);
        chk("rst_alloc fill rw", 128'(mem_req_rw), 128'd0);
        chk("rst_alloc fill addr", 128'(mem_req_addr), 128'h0000_AB00);
        @(negedge clk);
        chk("rst_alloc still busy", 128'(cache_ready), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_alloc mem_req_valid", 128'(mem_req_valid), 128'd0);
        chk("rst_alloc cache_ready", 128'(cache_ready), 128'd1);
        chk("rst_alloc dataout", 128'(cpu_req_dataout), 128'd0);
        chk("rst_alloc mem_req_addr", 128'(mem_req_addr), 128'd0);
        rst_n = 1'b0;
        @(negedge clk);
        post = mk(1'b0, 32'h0000_AB00, 128'h0, 128'hABAB, 0, 0, 32'h0, 128'h0,
                  1, 32'h0000_AB00, 32'hABAB, 0);
        do_req("post_reset_miss", post);
        // 0x30000 was valid before the reset; it must miss again.
        post = mk(1'b0, 32'h0003_0000, 128'h0, 128'h77, 0, 0, 32'h0, 128'h0,
                  1, 32'h0003_0000, 32'h77, 0);
        do_req("post_reset_miss2", post);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
